// File: rtl/universal_shift_reg_d_if.sv
// Parallel/serial data and mode bundle for the universal shift register.
// The controller side (master) drives mode and data; the register (slave) drives its state.
interface universal_shift_reg_d_if #(
  parameter int N = 4
);
  logic [1:0]   S;
  logic         sr_in;
  logic         sl_in;
  logic [N-1:0] P;
  logic [N-1:0] Q;
  logic [N-1:0] Qbar;
  logic         sr_out;
  logic         sl_out;

  modport master (
    output S, sr_in, sl_in, P,
    input  Q, Qbar, sr_out, sl_out
  );

  modport slave (
    input  S, sr_in, sl_in, P,
    output Q, Qbar, sr_out, sl_out
  );
endinterface

// File: rtl/universal_shift_reg_d.sv
// 74194-style universal shift register: a row of falling-edge D stages, each built
// from a T flip-flop with XOR feedback (T = D ^ Q) and fed by a 4:1 mode mux.
module universal_shift_reg_d #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    clr_bar,
  universal_shift_reg_d_if.slave  bus
);

  logic [N-1:0] q;
  logic [N-1:0] d;
  logic [N-1:0] t;

  always_comb begin
    d = q;
    case (bus.S)
      2'b00:   d = q;
      2'b01:   d = {bus.sr_in, q[N-1:1]};
      2'b10:   d = {q[N-2:0], bus.sl_in};
      default: d = bus.P;
    endcase
  end

  // Each D stage is a toggle flop whose T input is D ^ Q, so hold means T=0.
  assign t = d ^ q;

  always_ff @(negedge clk or negedge clr_bar) begin
    if (!clr_bar) begin
      q <= '0;
    end else begin
      q <= q ^ t;
    end
  end

  assign bus.Q      = q;
  assign bus.Qbar   = ~q;
  assign bus.sr_out = q[0];
  assign bus.sl_out = q[N-1];

endmodule

// File: doc/universal_shift_reg_d.md
Name: universal_shift_reg_d

Overview:
- N-bit universal shift register built as a row of D flip-flops, each fed by a 4:1 mode mux.
- Directly consumes the lab's D-flip-flop stage (a T flip-flop with XOR feedback, T = D ^ Q) and supplies the register stage used by later counter and sequence experiments.
- Behaviour matches the classic 74194: hold, shift right, shift left, parallel load.

Parameters:
- N, 4, register width in bits (legal range 2..16).

Ports:
- clk  input  1  clock; state updates on the falling edge, matching the master-slave flip-flops.
- clr_bar  input  1  asynchronous active-low reset; clears all bits.
- S  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_in  input  1  serial input for shift right; enters Q[N-1].
- sl_in  input  1  serial input for shift left; enters Q[0].
- P  input  N  parallel load data.
- Q  output  N  register contents.
- Qbar  output  N  bitwise complement of Q.
- sr_out  output  1  serial output for shift right, equal to Q[0].
- sl_out  output  1  serial output for shift left, equal to Q[N-1].

Behaviour:
- Reset is asynchronous and active-low.
  - clr_bar=0 forces Q=0, Qbar=all ones, sr_out=0, sl_out=0 immediately, independent of clk.
  - Reset is routed to every flip-flop clear; every flip-flop preset is tied inactive (1).
- While clr_bar=0, clock edges are ignored.
- Release of clr_bar takes effect at the next falling clk edge. No synchronizer is required; the bench releases reset while clk=1.
- All updates happen on the falling edge of clk, with latency 1 edge. S, sr_in, sl_in and P are sampled at that edge and must be stable while clk=1.
- Modes at each falling edge:
  - S=00 hold: Q unchanged. Each bit's D input is its own Q, so T=0 on every internal T flip-flop.
  - S=01 shift right: Q <= {sr_in, Q[N-1:1]}. The old Q[0] is discarded after being visible on sr_out before the edge.
  - S=10 shift left: Q <= {Q[N-2:0], sl_in}. The old Q[N-1] is discarded.
  - S=11 load: Q <= P.
- Outputs are pure wiring from state, with no combinational path from inputs to Q:
  - Qbar == ~Q at all times after settling.
  - sr_out == Q[0] and sl_out == Q[N-1].
- No internal state exists beyond the N flip-flops. There is no counter and no busy or done signal.
- Boundary conditions:
  - N shift-right edges with sr_in constant at b fill Q with all b.
  - A shift of all zeros or all ones leaves Q unchanged when the serial input matches.
  - Load and shift never overlap, because S is a single selector.
  - A mode change between edges takes effect only at the next edge.
  - Reset asserted mid-shift clears Q at once. The next operation after release starts from 0.
  - Reset asserted exactly at a falling edge: clear wins.
- Unknown inputs: if S is X or Z at an edge, Q may go X. The bench never drives this case.

Test Plan:
- Reset: clr_bar=0 with Q previously 1011, asserted while clk is low → Q=0000 and Qbar=1111 without any clk edge. After release, S=00 for 3 edges → Q stays 0000.
- Load and hold: S=11, P=1010 for one falling edge → Q=1010. Then S=00 for 4 edges → Q stays 1010, Qbar=0101, sr_out=0, sl_out=1.
- Shift right: load 1001, then S=01 with sr_in=1 for 4 edges → Q = 1100, 1110, 1111, 1111. sr_out before each edge = 1, 0, 0, 1.
- Shift left: load 0001, then S=10 with sl_in=0 for 4 edges → Q = 0010, 0100, 1000, 0000. sl_out = 0, 0, 1, 0 after each edge.
- Reset mid-operation: load 0110, do 1 shift-left edge (sl_in=1) → Q=1101. Pulse clr_bar low while clk=1 → Q=0000 at once. Release, then S=01 with sr_in=1 for 1 edge → Q=1000.
- Mode switch per edge with the serial-in/serial-out loop: tie sr_in=sr_out, load 0011, S=01 for 4 edges → Q = 1001, 1100, 0110, 0011 (rotate). Then S=11, P=1111 → Q=1111.
